// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the processor register file slice.
//
//   Contents:
//     REG_SELECT_WIDTH  default register index width
//     REG_DATA_WIDTH    default register / data-port width
//     REG_COUNT         number of registers for the default index width
//     ZERO_REG_IDX      index of the register that may be hard-wired to zero
//     reg_addr_t        register index type (default width)
//     reg_data_t        register data type (default width)
//     isZeroReg()       true when an index names the zero register
// ----------------------------------------------------------------------------
package regfile_pkg;

  localparam int REG_SELECT_WIDTH = 5;
  localparam int REG_DATA_WIDTH   = 32;
  localparam int REG_COUNT        = 2 ** REG_SELECT_WIDTH;

  localparam int ZERO_REG_IDX = 0;

  typedef logic [REG_SELECT_WIDTH-1:0] reg_addr_t;
  typedef logic [REG_DATA_WIDTH-1:0]   reg_data_t;

  // Index comparison against the zero register, independent of index width.
  function automatic logic isZeroReg(input int unsigned idx);
    return (idx == ZERO_REG_IDX);
  endfunction

endpackage : regfile_pkg

// File: rtl/nbit_demux.sv
// ----------------------------------------------------------------------------
// nbit_demux
//   1-to-2**SELECT_WIDTH demultiplexer. Routes the single input bit to the
//   output selected by DeMuxSel; every other output is 0. Used as the
//   register-file write-enable decoder (input = write strobe, select = index).
//
//   Parameters:
//     SELECT_WIDTH  select width; output count = 2**SELECT_WIDTH
//
//   Ports:
//     DeMuxIn   in   1              bit to route
//     DeMuxSel  in   SELECT_WIDTH   destination output index
//     DeMuxOut  out  2**SELECT_WIDTH  one-hot copy of DeMuxIn (all 0 if In=0)
// ----------------------------------------------------------------------------
module nbit_demux #(
  parameter int SELECT_WIDTH = 5
) (
  input  logic                         DeMuxIn,
  input  logic [SELECT_WIDTH-1:0]      DeMuxSel,
  output logic [(2**SELECT_WIDTH)-1:0] DeMuxOut
);

  always_comb begin
    DeMuxOut           = '0;
    DeMuxOut[DeMuxSel] = DeMuxIn;
  end

endmodule : nbit_demux

// File: rtl/reg_file_bank.sv
// ----------------------------------------------------------------------------
// reg_file_bank
//   General-purpose register file for the multicycle datapath. Holds
//   2**SELECT_WIDTH registers of DATA_WIDTH bits, written through a one-hot
//   enable vector produced by nbit_demux, and read through two registered
//   ports that double as the datapath A/B latches.
//
//   Parameters:
//     SELECT_WIDTH  register index width (register count = 2**SELECT_WIDTH)
//     DATA_WIDTH    register and data-port width
//     ZERO_REG      1: register 0 ignores writes and always reads 0
//
//   Build option:
//     REG_FILE_WRITE_BYPASS_EN  when defined, a read launched on the same edge
//                               as a write to the same index returns the new
//                               WriteData; otherwise it returns the old value.
//
//   Ports:
//     Clk         in   1                rising-edge clock
//     Reset       in   1                synchronous active-high reset; clears
//                                       all registers and both read latches
//     RegWrite    in   1                write strobe
//     WriteAddr   in   SELECT_WIDTH     destination register index
//     WriteData   in   DATA_WIDTH       write data
//     ReadEn      in   1                1: both read latches load this edge
//     ReadAddrA   in   SELECT_WIDTH     port A source index
//     ReadAddrB   in   SELECT_WIDTH     port B source index
//     ReadDataA   out  DATA_WIDTH       registered port A data
//     ReadDataB   out  DATA_WIDTH       registered port B data
//     WriteEnVec  out  2**SELECT_WIDTH  combinational one-hot write enables
// ----------------------------------------------------------------------------
module reg_file_bank
  import regfile_pkg::*;
#(
  parameter int SELECT_WIDTH = REG_SELECT_WIDTH,
  parameter int DATA_WIDTH   = REG_DATA_WIDTH,
  parameter int ZERO_REG     = 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         RegWrite,
  input  logic [SELECT_WIDTH-1:0]      WriteAddr,
  input  logic [DATA_WIDTH-1:0]        WriteData,
  input  logic                         ReadEn,
  input  logic [SELECT_WIDTH-1:0]      ReadAddrA,
  input  logic [SELECT_WIDTH-1:0]      ReadAddrB,
  output logic [DATA_WIDTH-1:0]        ReadDataA,
  output logic [DATA_WIDTH-1:0]        ReadDataB,
  output logic [(2**SELECT_WIDTH)-1:0] WriteEnVec
);

  localparam int REG_NUM = 2 ** SELECT_WIDTH;
  localparam logic [SELECT_WIDTH-1:0] ZERO_ADDR = SELECT_WIDTH'(ZERO_REG_IDX);
  localparam bit ZERO_ON = (ZERO_REG != 0);

  // --------------------------------------------------------------------------
  // Write-enable decode
  // --------------------------------------------------------------------------
  nbit_demux #(
    .SELECT_WIDTH (SELECT_WIDTH)
  ) writeDecoder (
    .DeMuxIn  (RegWrite),
    .DeMuxSel (WriteAddr),
    .DeMuxOut (WriteEnVec)
  );

  // Per-register load enables: the decoder output with the zero register
  // masked off when it is hard-wired. WriteEnVec itself stays unmasked so the
  // debug view always reflects the raw decode.
  logic [REG_NUM-1:0] loadEn;

  always_comb begin
    loadEn = WriteEnVec;
    if (ZERO_ON) begin
      loadEn[ZERO_REG_IDX] = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Register storage
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs [REG_NUM];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (loadEn[i]) begin
          regs[i] <= WriteData;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read-port source selection
  //   Priority: zero register (if hard-wired) > same-edge bypass (if built)
  //   > stored value. The zero check must win over bypass so a write aimed
  //   at register 0 can never leak through a read port.
  // --------------------------------------------------------------------------
  logic                  zeroHitA;
  logic                  zeroHitB;
  logic                  bypassHitA;
  logic                  bypassHitB;
  logic [DATA_WIDTH-1:0] nextA;
  logic [DATA_WIDTH-1:0] nextB;

  always_comb begin
    zeroHitA = ZERO_ON && (ReadAddrA == ZERO_ADDR);
    zeroHitB = ZERO_ON && (ReadAddrB == ZERO_ADDR);
  end

`ifdef REG_FILE_WRITE_BYPASS_EN
  always_comb begin
    bypassHitA = RegWrite && (ReadAddrA == WriteAddr);
    bypassHitB = RegWrite && (ReadAddrB == WriteAddr);
  end
`else
  // Without forwarding a same-edge read sees the value stored before the
  // write, which is exactly what the flop array presents this cycle.
  always_comb begin
    bypassHitA = 1'b0;
    bypassHitB = 1'b0;
  end
`endif

  always_comb begin
    nextA = regs[ReadAddrA];
    if (zeroHitA) begin
      nextA = '0;
    end else if (bypassHitA) begin
      nextA = WriteData;
    end
  end

  always_comb begin
    nextB = regs[ReadAddrB];
    if (zeroHitB) begin
      nextB = '0;
    end else if (bypassHitB) begin
      nextB = WriteData;
    end
  end

  // --------------------------------------------------------------------------
  // Read latches (datapath A/B). Hold when ReadEn is low.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ReadDataA <= '0;
      ReadDataB <= '0;
    end else if (ReadEn) begin
      ReadDataA <= nextA;
      ReadDataB <= nextB;
    end
  end

endmodule : reg_file_bank

// File: tb/tb_reg_file_bank.sv
// ----------------------------------------------------------------------------
// tb_reg_file_bank
//   Two instances share every input: dutZ (ZERO_REG=1) and dutN (ZERO_REG=0).
//   A behavioural model (plain arrays) tracks both register files and both
//   pairs of read latches.
// ----------------------------------------------------------------------------
module tb_reg_file_bank;

  logic        clk;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic        readEn;
  logic [4:0]  readAddrA;
  logic [4:0]  readAddrB;

  logic [31:0] rdAZ, rdBZ, wevZ;
  logic [31:0] rdAN, rdBN, wevN;

  int vectors;
  int miscompares;

  // model: index 0 -> ZERO_REG=0 build, index 1 -> ZERO_REG=1 build
  logic [31:0] mMem [2][32];
  logic [31:0] mA [2];
  logic [31:0] mB [2];

  reg_file_bank #(.SELECT_WIDTH(5), .DATA_WIDTH(32), .ZERO_REG(1)) dutZ (
    .Clk(clk), .Reset(reset), .RegWrite(regWrite), .WriteAddr(writeAddr),
    .WriteData(writeData), .ReadEn(readEn), .ReadAddrA(readAddrA),
    .ReadAddrB(readAddrB), .ReadDataA(rdAZ), .ReadDataB(rdBZ),
    .WriteEnVec(wevZ)
  );

  reg_file_bank #(.SELECT_WIDTH(5), .DATA_WIDTH(32), .ZERO_REG(0)) dutN (
    .Clk(clk), .Reset(reset), .RegWrite(regWrite), .WriteAddr(writeAddr),
    .WriteData(writeData), .ReadEn(readEn), .ReadAddrA(readAddrA),
    .ReadAddrB(readAddrB), .ReadDataA(rdAN), .ReadDataB(rdBN),
    .WriteEnVec(wevN)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [31:0] modelRead(input int z, input int a);
    if (z == 1 && a == 0) return 32'h0;
`ifdef REG_FILE_WRITE_BYPASS_EN
    if (regWrite && a == int'(writeAddr)) return writeData;
`endif
    return mMem[z][a];
  endfunction

  function automatic logic [31:0] modelWev();
    logic [31:0] v;
    v = regWrite ? (32'd1 << writeAddr) : 32'd0;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic we, input int wa,
                       input logic [31:0] wd, input logic re,
                       input int ra, input int rb);
    reset     = rst;
    regWrite  = we;
    writeAddr = 5'(wa);
    writeData = wd;
    readEn    = re;
    readAddrA = 5'(ra);
    readAddrB = 5'(rb);
    #1;
  endtask

  // Advance one edge with the currently driven inputs; model first, then clock.
  task automatic tick();
    for (int z = 0; z < 2; z++) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) mMem[z][i] = 32'h0;
        mA[z] = 32'h0;
        mB[z] = 32'h0;
      end else begin
        if (readEn) begin
          mA[z] = modelRead(z, int'(readAddrA));
          mB[z] = modelRead(z, int'(readAddrB));
        end
        if (regWrite && !(z == 1 && writeAddr == 5'd0))
          mMem[z][writeAddr] = writeData;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic rst, input logic we, input int wa,
                      input logic [31:0] wd, input logic re,
                      input int ra, input int rb);
    drive(rst, we, wa, wd, re, ra, rb);
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // arbitrary writes first, then two reset edges
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, $urandom_range(0, 31), $urandom, 1'b1,
           $urandom_range(0, 31), $urandom_range(0, 31));
    step(1'b1, 1'b1, 9, 32'h1234_5678, 1'b1, 9, 9);
    step(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 0);
    vectors++;
    if (rdAZ !== 32'h0 || rdBZ !== 32'h0 || rdAN !== 32'h0 || rdBN !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_latches: got %h %h %h %h expected all 0", rdAZ, rdBZ, rdAN, rdBN);
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 0, 32'h0, 1'b1, i, 31 - i);
      vectors++;
      if (rdAZ !== 32'h0 || rdBZ !== 32'h0 || rdAN !== 32'h0 || rdBN !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_read r%0d: got %h %h %h %h expected all 0", i, rdAZ, rdBZ, rdAN, rdBN);
      end
    end
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 0);
    vectors++;
    if (wevZ !== 32'h0000_0020 || wevN !== 32'h0000_0020) begin
      miscompares++;
      $display("FAIL wev_r5: got %h %h expected 00000020", wevZ, wevN);
    end
    tick();
    step(1'b0, 1'b0, 0, 32'h0, 1'b1, 5, 5);
    vectors++;
    if (rdAZ !== 32'hDEAD_BEEF || rdBN !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL read_r5: got %h %h expected deadbeef", rdAZ, rdBN);
    end
  endtask

  task automatic test_zero_reg();
    step(1'b0, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 32'h0, 1'b1, 0, 0);
    vectors++;
    if (rdAZ !== 32'h0 || rdBZ !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_reg_on: got %h %h expected 0", rdAZ, rdBZ);
    end
    vectors++;
    if (rdAN !== 32'hFFFF_FFFF || rdBN !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL zero_reg_off: got %h %h expected ffffffff", rdAN, rdBN);
    end
    // same-edge write+read of R0: must read 0 in the zero build either way
    step(1'b0, 1'b1, 0, 32'h5A5A_5A5A, 1'b1, 0, 0);
    vectors++;
    if (rdAZ !== 32'h0 || rdAN !== mA[0]) begin
      miscompares++;
      $display("FAIL zero_reg_same_edge: got %h %h expected 0 %h", rdAZ, rdAN, mA[0]);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] expFirst;
`ifdef REG_FILE_WRITE_BYPASS_EN
    expFirst = 32'h2222_2222;
`else
    expFirst = 32'h1111_1111;
`endif
    step(1'b0, 1'b1, 7, 32'h1111_1111, 1'b0, 0, 0);
    step(1'b0, 1'b1, 7, 32'h2222_2222, 1'b1, 7, 3);
    vectors++;
    if (rdAZ !== expFirst || rdAN !== expFirst) begin
      miscompares++;
      $display("FAIL same_edge_r7: got %h %h expected %h", rdAZ, rdAN, expFirst);
    end
    step(1'b0, 1'b0, 0, 32'h0, 1'b1, 7, 7);
    vectors++;
    if (rdAZ !== 32'h2222_2222 || rdBN !== 32'h2222_2222) begin
      miscompares++;
      $display("FAIL after_same_edge_r7: got %h %h expected 22222222", rdAZ, rdBN);
    end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b1, 1, 32'hA, 1'b0, 0, 0);
    step(1'b0, 1'b1, 2, 32'hB, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1, 2);
    step(1'b0, 1'b1, 1, 32'hCAFE_0001, 1'b0, 1, 2);
    step(1'b0, 1'b1, 2, 32'hCAFE_0002, 1'b0, 2, 1);
    vectors++;
    if (rdAZ !== 32'hA || rdBZ !== 32'hB || rdAN !== 32'hA || rdBN !== 32'hB) begin
      miscompares++;
      $display("FAIL hold: got %h %h %h %h expected a b a b", rdAZ, rdBZ, rdAN, rdBN);
    end
    step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1, 2);
    vectors++;
    if (rdAZ !== 32'hCAFE_0001 || rdBZ !== 32'hCAFE_0002) begin
      miscompares++;
      $display("FAIL hold_release: got %h %h expected cafe0001 cafe0002", rdAZ, rdBZ);
    end
  endtask

  task automatic test_reset_priority();
    step(1'b1, 1'b1, 3, 32'h5, 1'b1, 3, 3);
    drive(1'b0, 1'b0, 3, 32'hFFFF_0000, 1'b1, 3, 1);
    vectors++;
    if (wevZ !== 32'h0 || wevN !== 32'h0) begin
      miscompares++;
      $display("FAIL wev_idle: got %h %h expected 0", wevZ, wevN);
    end
    tick();
    vectors++;
    if (rdAZ !== 32'h0 || rdAN !== 32'h0 || rdBN !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_discards_write: got %h %h %h expected 0", rdAZ, rdAN, rdBN);
    end
  endtask

  task automatic test_random();
    int wa, ra, rb;
    logic [31:0] expW;
    for (int n = 0; n < 400; n++) begin
      wa = $urandom_range(0, 31);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 31);
      drive($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), wa, $urandom,
            $urandom_range(0, 3) != 0, ra, rb);
      expW = modelWev();
      vectors++;
      if (wevZ !== expW || wevN !== expW) begin
        miscompares++;
        $display("FAIL rand_wev #%0d: got %h %h expected %h", n, wevZ, wevN, expW);
      end
      tick();
      vectors++;
      if (rdAZ !== mA[1] || rdBZ !== mB[1] || rdAN !== mA[0] || rdBN !== mB[0]) begin
        miscompares++;
        $display("FAIL rand_read #%0d: got %h %h %h %h expected %h %h %h %h",
                 n, rdAZ, rdBZ, rdAN, rdBN, mA[1], mB[1], mA[0], mB[0]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 32; i++) mMem[z][i] = 32'h0;
      mA[z] = 32'h0;
      mB[z] = 32'h0;
    end
    drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 0);
    @(negedge clk);
    test_reset();
    test_write_read();
    test_zero_reg();
    test_same_edge();
    test_hold();
    test_reset_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_file_bank
